// File: rtl/m_cycle.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle, width cycles per op.
// Define MCYCLE_DIV_EN to build the divider; without it, ops 10/11 run the full Busy sequence and return zero.
module m_cycle #(
    parameter int width = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [width-1:0] Operand1,
    input  logic [width-1:0] Operand2,
    output logic [width-1:0] Result1,
    output logic [width-1:0] Result2,
    output logic             Busy
);

    localparam int            CW        = $clog2(width + 1);
    localparam logic [CW-1:0] LastCount = CW'(width - 1);

    typedef enum logic {IDLE, COMPUTING} state_t;

    state_t           state_q,   state_d;
    logic [CW-1:0]    count_q,   count_d;
    logic             isDiv_q,   isDiv_d;
    logic             resNeg_q,  resNeg_d;
    logic [width-1:0] hi_q,      hi_d;
    logic [width-1:0] lo_q,      lo_d;
    logic [width-1:0] addend_q,  addend_d;
    logic [width-1:0] result1_q, result1_d;
    logic [width-1:0] result2_q, result2_d;
`ifdef MCYCLE_DIV_EN
    logic             remNeg_q,  remNeg_d;
    logic             divZero_q, divZero_d;
`endif

    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [width-1:0] aMag;
    logic [width-1:0] bMag;

    // Signed operands are reduced to magnitudes at launch; the signs are reapplied at completion.
    always_comb begin
        signedOp = ~MCycleOp[0];
        aNeg     = signedOp & Operand1[width-1];
        bNeg     = signedOp & Operand2[width-1];
        aMag     = aNeg ? -Operand1 : Operand1;
        bMag     = bNeg ? -Operand2 : Operand2;
    end

    logic [width:0]     mulSum;
    logic [2*width-1:0] product;
`ifdef MCYCLE_DIV_EN
    logic [width:0]     divShift;
    logic               divFits;
    logic [width-1:0]   quotient;
    logic [width-1:0]   remainder;
`endif

    always_comb begin
        mulSum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? addend_q : {width{1'b0}})};
`ifdef MCYCLE_DIV_EN
        divShift = {hi_q, lo_q[width-1]};
        divFits  = (divShift >= {1'b0, addend_q});
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        isDiv_d   = isDiv_q;
        resNeg_d  = resNeg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        addend_d  = addend_q;
        result1_d = result1_q;
        result2_d = result2_q;
        product   = '0;
`ifdef MCYCLE_DIV_EN
        remNeg_d  = remNeg_q;
        divZero_d = divZero_q;
        quotient  = '0;
        remainder = '0;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = COMPUTING;
                    count_d  = '0;
                    isDiv_d  = MCycleOp[1];
                    resNeg_d = aNeg ^ bNeg;
                    hi_d     = '0;
                    // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
                    lo_d     = MCycleOp[1] ? aMag : bMag;
                    addend_d = MCycleOp[1] ? bMag : aMag;
`ifdef MCYCLE_DIV_EN
                    remNeg_d  = aNeg;
                    divZero_d = (Operand2 == '0);
`endif
                end
            end

            COMPUTING: begin
                count_d = count_q + CW'(1);
`ifdef MCYCLE_DIV_EN
                if (isDiv_q) begin
                    hi_d = divFits ? (divShift[width-1:0] - addend_q) : divShift[width-1:0];
                    lo_d = {lo_q[width-2:0], divFits};
                end else begin
                    hi_d = mulSum[width:1];
                    lo_d = {mulSum[0], lo_q[width-1:1]};
                end
`else
                hi_d = mulSum[width:1];
                lo_d = {mulSum[0], lo_q[width-1:1]};
`endif

                // Last iteration: results are formed from this cycle's step so they land on edge k+width.
                if (count_q == LastCount) begin
                    state_d = IDLE;
                    count_d = '0;
                    product = resNeg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
`ifdef MCYCLE_DIV_EN
                    quotient  = divZero_q ? {width{1'b1}} : (resNeg_q ? -lo_d : lo_d);
                    remainder = remNeg_q ? -hi_d : hi_d;
                    if (isDiv_q) begin
                        result1_d = quotient;
                        result2_d = remainder;
                    end else begin
                        result1_d = product[width-1:0];
                        result2_d = product[2*width-1:width];
                    end
`else
                    if (isDiv_q) begin
                        result1_d = '0;
                        result2_d = '0;
                    end else begin
                        result1_d = product[width-1:0];
                        result2_d = product[2*width-1:width];
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            isDiv_q   <= 1'b0;
            resNeg_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            addend_q  <= '0;
            result1_q <= '0;
            result2_q <= '0;
`ifdef MCYCLE_DIV_EN
            remNeg_q  <= 1'b0;
            divZero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            isDiv_q   <= isDiv_d;
            resNeg_q  <= resNeg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            addend_q  <= addend_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
`ifdef MCYCLE_DIV_EN
            remNeg_q  <= remNeg_d;
            divZero_q <= divZero_d;
`endif
        end
    end

    assign Result1 = result1_q;
    assign Result2 = result2_q;
    assign Busy    = (state_q == COMPUTING);

endmodule

// File: tb/tb_m_cycle.sv
// Directed bench for m_cycle at width 4; division expectations collapse to zero when MCYCLE_DIV_EN is not defined.
module tb_m_cycle;

`ifdef MCYCLE_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic       CLK;
    logic       RESET;
    logic       Start;
    logic [1:0] MCycleOp;
    logic [3:0] Operand1;
    logic [3:0] Operand2;
    logic [3:0] Result1;
    logic [3:0] Result2;
    logic       Busy;

    int checks     = 0;
    int failures   = 0;
    int busyCycles = 0;

    m_cycle #(.width(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] divExp(input logic [3:0] v);
        return DivEn ? v : 4'h0;
    endfunction

    // Launch one op, scramble the inputs mid-operation, and count Busy cycles with a bound.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(negedge CLK);
        Start    = 1'b0;
        MCycleOp = ~op;
        Operand1 = ~a;
        Operand2 = ~b;
        busyCycles = 0;
        while (Busy && busyCycles < 20) begin
            busyCycles++;
            @(negedge CLK);
        end
    endtask

    task automatic runVector(input string tag, input logic [1:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] exp1, input logic [3:0] exp2);
        applyStimulus(op, a, b);
        checkOutput({tag, "_r1"}, {4'h0, Result1}, {4'h0, exp1});
        checkOutput({tag, "_r2"}, {4'h0, Result2}, {4'h0, exp2});
        checkOutput({tag, "_busy"}, 8'(busyCycles), 8'd4);
    endtask

    initial begin
        RESET    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = 4'h0;
        Operand2 = 4'h0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_busy", {7'h0, Busy}, 8'h00);
        checkOutput("reset_r1", {4'h0, Result1}, 8'h00);
        checkOutput("reset_r2", {4'h0, Result2}, 8'h00);
        RESET = 1'b0;

        runVector("smul_m1_m1",  2'b00, 4'b1111, 4'b1111, 4'b0001, 4'b0000);
        runVector("smul_m3_2",   2'b00, 4'b1101, 4'b0010, 4'b1010, 4'b1111);
        runVector("umul_2_6",    2'b01, 4'b0010, 4'b0110, 4'b1100, 4'b0000);
        runVector("smul_m8_m8",  2'b00, 4'b1000, 4'b1000, 4'b0000, 4'b0100);
        runVector("umul_15_15",  2'b01, 4'b1111, 4'b1111, 4'b0001, 4'b1110);
        runVector("smul_7_m8",   2'b00, 4'b0111, 4'b1000, 4'b1000, 4'b1100);

        runVector("sdiv_m4_3",   2'b10, 4'b1100, 4'b0011, divExp(4'b1111), divExp(4'b1111));
        runVector("sdiv_m6_m4",  2'b10, 4'b1010, 4'b1100, divExp(4'b0001), divExp(4'b1110));
        runVector("udiv_8_4",    2'b11, 4'b1000, 4'b0100, divExp(4'b0010), divExp(4'b0000));
        runVector("udiv_5_0",    2'b11, 4'b0101, 4'b0000, divExp(4'b1111), divExp(4'b0101));
        runVector("sdiv_m8_m1",  2'b10, 4'b1000, 4'b1111, divExp(4'b1000), divExp(4'b0000));
        runVector("sdiv_m7_0",   2'b10, 4'b1001, 4'b0000, divExp(4'b1111), divExp(4'b1001));
        runVector("udiv_15_3",   2'b11, 4'b1111, 4'b0011, divExp(4'b0101), divExp(4'b0000));
        runVector("sdiv_7_m2",   2'b10, 4'b0111, 4'b1110, divExp(4'b1101), divExp(4'b0001));

        // Start held high: second op must capture the operands present at its own launch edge.
        @(negedge CLK);
        MCycleOp = 2'b01;
        Operand1 = 4'd3;
        Operand2 = 4'd5;
        Start    = 1'b1;
        @(negedge CLK);
        checkOutput("b2b_launch_busy", {7'h0, Busy}, 8'h01);
        Operand1 = 4'd2;
        Operand2 = 4'd7;
        busyCycles = 0;
        while (Busy && busyCycles < 20) begin
            busyCycles++;
            @(negedge CLK);
        end
        checkOutput("b2b_first_busy", 8'(busyCycles), 8'd4);
        checkOutput("b2b_first_r1", {4'h0, Result1}, 8'h0F);
        checkOutput("b2b_first_r2", {4'h0, Result2}, 8'h00);
        @(negedge CLK);
        checkOutput("b2b_relaunch_busy", {7'h0, Busy}, 8'h01);
        checkOutput("b2b_hold_r1", {4'h0, Result1}, 8'h0F);
        Start    = 1'b0;
        Operand1 = 4'hF;
        Operand2 = 4'hF;
        busyCycles = 0;
        while (Busy && busyCycles < 20) begin
            busyCycles++;
            @(negedge CLK);
        end
        checkOutput("b2b_second_busy", 8'(busyCycles), 8'd4);
        checkOutput("b2b_second_r1", {4'h0, Result1}, 8'h0E);
        checkOutput("b2b_second_r2", {4'h0, Result2}, 8'h00);

        // Reset two cycles into an operation aborts it and clears the results.
        @(negedge CLK);
        MCycleOp = 2'b00;
        Operand1 = 4'b0111;
        Operand2 = 4'b0011;
        Start    = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", {7'h0, Busy}, 8'h00);
        checkOutput("abort_r1", {4'h0, Result1}, 8'h00);
        checkOutput("abort_r2", {4'h0, Result2}, 8'h00);
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        checkOutput("abort_idle_busy", {7'h0, Busy}, 8'h00);
        checkOutput("abort_idle_r1", {4'h0, Result1}, 8'h00);
        runVector("post_reset", 2'b00, 4'b0111, 4'b0011, 4'b0101, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
